// File: rtl/result_tx_fifo.sv
// result_tx_fifo
// Result buffer between the summer/FSM stage and the PS-side stream adapter.
// It captures one `sum` word on each cycle in_valid is high and holds up to
// DEPTH words. Words leave first-word-fall-through on a valid/ready stream.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   in_data/valid   write side (upstream sum / send_data)
//   out_data/valid  head word, forced to 0 when empty; valid = non-empty
//   out_ready       consumer takes the head when out_valid & out_ready
//   level           stored entries, 0..DEPTH
//   full/empty      level == DEPTH / level == 0
//   overflow        sticky: a write was dropped while full; cleared by clr_ovf
//   clr_ovf         synchronous overflow clear (a same-cycle drop wins)
//   result_cnt      accepted writes since reset, wraps silently
module result_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  input  logic                  clr_ovf,
  output logic [CNT_WIDTH-1:0]  result_cnt
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LVL_FULL = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_level;
  logic                  r_ovf;
  logic [CNT_WIDTH-1:0]  r_cnt;

  logic w_full, w_empty, w_rd, w_wr, w_drop;

  assign w_full  = (r_level == LVL_FULL);
  assign w_empty = (r_level == '0);
  // A read frees the slot the write needs, so a full buffer can still take a
  // write when the head leaves on the same edge.
  assign w_rd    = ~w_empty & out_ready;
  assign w_wr    = in_valid & (~w_full | w_rd);
  assign w_drop  = in_valid & ~w_wr;

  // Storage is deliberately not reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
        r_cnt    <= r_cnt + CNT_WIDTH'(1);
      end
      if (w_rd) r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + (ADDR_WIDTH+1)'(1);
        2'b01:   r_level <= r_level - (ADDR_WIDTH+1)'(1);
        default: r_level <= r_level;
      endcase
      // Set has priority over clear so a drop is never lost.
      if (w_drop)       r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

  assign out_valid  = ~w_empty;
  assign out_data   = w_empty ? '0 : r_mem[r_rd_ptr];
  assign level      = r_level;
  assign full       = w_full;
  assign empty      = w_empty;
  assign overflow   = r_ovf;
  assign result_cnt = r_cnt;
endmodule

// File: tb/tb_result_tx_fifo.sv
module tb_result_tx_fifo;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  level;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        clr_ovf;
  logic [15:0] result_cnt;

  result_tx_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .full(full), .empty(empty), .overflow(overflow),
    .clr_ovf(clr_ovf), .result_cnt(result_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a plain queue of stored words plus sticky flag and count.
  logic [7:0]  q[$];
  logic        m_ovf = 1'b0;
  logic [15:0] m_cnt = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("out_valid", 32'(out_valid), 32'(n != 0));
    chk("out_data", 32'(out_data), (n != 0) ? 32'(q[0]) : 32'd0);
    chk("level", 32'(level), 32'(n));
    chk("full", 32'(full), 32'(n == 8));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("result_cnt", 32'(result_cnt), 32'(m_cnt));
  endtask

  // One clock: drive inputs, apply the transfer rules to the model at the
  // edge, then check every output just after the edge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic r, input logic c);
    bit rd, wr;
    in_valid = v; in_data = d; out_ready = r; clr_ovf = c;
    @(posedge clk);
    rd = (q.size() != 0) && r;
    wr = v && ((q.size() < 8) || rd);
    if (rd) void'(q.pop_front());
    if (wr) begin q.push_back(d); m_cnt = m_cnt + 16'd1; end
    if (v && !wr) m_ovf = 1'b1;
    else if (c)   m_ovf = 1'b0;
    #1 check_all();
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_data = 0; out_ready = 0; clr_ovf = 0;
    repeat (2) @(posedge clk);
    #1 check_all();
    rst = 1'b0;

    // Idle read on empty
    cyc(0, 8'h00, 1, 0);
    chk("idle_level", 32'(level), 32'd0);

    // Single transfer
    cyc(1, 8'h2A, 0, 0);
    chk("single_data", 32'(out_data), 32'h2A);
    chk("single_cnt", 32'(result_cnt), 32'd1);
    cyc(0, 8'h00, 1, 0);
    chk("single_empty", 32'(empty), 32'd1);

    // Fill, partial read, wrap
    for (int i = 1; i <= 8; i++) cyc(1, 8'(i), 0, 0);
    chk("fill_full", 32'(full), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      chk("rd_head", 32'(out_data), 32'(i));
      cyc(0, 8'h00, 1, 0);
    end
    for (int i = 9; i <= 11; i++) cyc(1, 8'(i), 0, 0);
    for (int i = 4; i <= 11; i++) begin
      chk("wrap_drain", 32'(out_data), 32'(i));
      cyc(0, 8'h00, 1, 0);
    end

    // Overflow: drop, clear-with-drop, clear alone
    for (int i = 0; i < 8; i++) cyc(1, 8'(8'h10 + i), 0, 0);
    cyc(1, 8'hFF, 0, 0);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_cnt", 32'(result_cnt), 32'd20);
    cyc(1, 8'hFE, 0, 1);
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    cyc(0, 8'h00, 0, 1);
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Simultaneous write/read while full
    cyc(1, 8'h20, 1, 0);
    chk("sim_level", 32'(level), 32'd8);
    chk("sim_head", 32'(out_data), 32'h11);
    for (int i = 0; i < 8; i++) begin
      chk("sim_drain", 32'(out_data), (i == 7) ? 32'h20 : 32'(8'h11 + i));
      cyc(0, 8'h00, 1, 0);
    end

    // Reset mid-stream takes effect without a clock edge
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'h30 + i), 0, 0);
    in_valid = 0;
    #3 rst = 1'b1;
    #1;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    q.delete(); m_ovf = 1'b0; m_cnt = '0;
    check_all();
    @(negedge clk) rst = 1'b0;
    cyc(1, 8'h55, 0, 0);
    chk("post_rst_data", 32'(out_data), 32'h55);
    chk("post_rst_level", 32'(level), 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0, 8'($urandom),
          ($urandom_range(0, 99) < 50) ? 1'b1 : 1'b0,
          ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0);
    for (int i = 0; i < 9; i++) cyc(0, 8'h00, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
